reg_bank: RTL and testbench
===========================

Name: reg_bank

Overview:
- Register bank on the receive side of the write-back path; the write-back mux output feeds in_WB.
- Stores NREGS words; register 0 is hardwired to zero.
- Provides two combinational read ports (A, B) for the operand stage and one synchronous write port.
- After reset, a sequential clear engine zeroes every register and holds busy high until the bank is valid.

Parameters:
DATA_W, 32, data word width
ADDR_W, 5, register address width; NREGS = 2**ADDR_W

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
WE_RB  input  1  write enable from control unit
addr_W  input  ADDR_W  write register index
in_WB  input  DATA_W  write-back data (from write-back mux)
addr_A  input  ADDR_W  read port A index
addr_B  input  ADDR_W  read port B index
out_A  output  DATA_W  read port A data
out_B  output  DATA_W  read port B data
busy  output  1  clear sequence in progress
wr_dropped  output  1  sticky: a write was ignored while busy

Behaviour:
- One clock. Reset is synchronous and active-high: sampled only on the rising edge of clock.
- FSM states: CLEAR, READY.
- While reset is high at an edge:
  - state <= CLEAR, cnt <= 1
  - wr_dropped <= 0
  - busy reads 1 (busy is high exactly when state == CLEAR)
- CLEAR, reset low:
  - Each edge: reg[cnt] <= 0, cnt <= cnt + 1.
  - On the edge where cnt == NREGS-1: write reg[NREGS-1] <= 0 and go to READY.
  - busy is therefore high for NREGS-1 (31) edges after reset deasserts; it falls after the edge that clears reg[31].
- Writes arriving during CLEAR:
  - WE_RB high at an edge with addr_W != 0 is ignored, and wr_dropped <= 1.
  - WE_RB with addr_W == 0 never sets wr_dropped.
- Reads during CLEAR: out_A and out_B = 0 regardless of address.
- READY:
  - WE_RB high at an edge with addr_W != 0: reg[addr_W] <= in_WB.
  - addr_W == 0: write discarded silently.
- Reads in READY: out_A = (addr_A == 0) ? 0 : reg[addr_A]; same rule for out_B. Combinational, zero latency.
- Both ports may address the same register; both return the same value.
- Without bypass, a write becomes visible on the read ports in the cycle after the edge that performs it.
- Reset asserted mid-CLEAR or in READY restarts the sequence (cnt <= 1). Previously stored data is cleared by the new sequence.
- wr_dropped is cleared only by reset.
- cnt is ADDR_W bits wide; it never wraps, because the FSM leaves CLEAR at NREGS-1.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined: in READY, if WE_RB == 1, addr_W != 0 and addr_A == addr_W, then out_A = in_WB in the same cycle (write-through). Same rule for port B. Bypass is inactive during CLEAR.
- Undefined: no bypass; reads return the stored value, so the old value is seen until the edge.

Decomposition:
- Shared package rb_pkg holds:
  - DATA_W and ADDR_W defaults
  - constant R0 = 0
  - state typedef {CLEAR, READY}
- One sub-module, reg_bank_init: the clear FSM plus counter.
  - Outputs: busy, clr_we, clr_addr.
  - The top muxes the clear write against WE_RB.

Test Plan:
- Reset for 2 cycles, release -> busy = 1 for exactly 31 edges then 0; afterwards out_A = out_B = 0 for every addr 1..31.
- READY: write 32'hFFFF0000 to r5, then 32'h0000FFFF to r6; next cycle addr_A = 5, addr_B = 6 -> out_A = 32'hFFFF0000, out_B = 32'h0000FFFF.
- Write 32'hFFFFFFFF to r0 -> addr_A = 0 reads 0; wr_dropped stays 0.
- WE_RB = 1, addr_W = 3, in_WB = 32'h12345678 during CLEAR -> wr_dropped = 1 after the edge; r3 reads 0 after busy falls.
- Same-cycle write r7 = 32'hA5A5A5A5 with addr_A = 7 (old value 0) -> out_A = 32'hA5A5A5A5 before the edge with REG_BANK_BYPASS_EN defined; 0 without it. Both builds read 32'hA5A5A5A5 after the edge.
- Assert reset at CLEAR cycle 10, release -> busy restarts and lasts a full 31 edges; wr_dropped is cleared.

Source files
------------

// File: rtl/rb_pkg.sv
// Shared definitions for the register bank: default widths, the
// hardwired-zero register index and the clear-engine state type.
package rb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Index of the register that always reads as zero.
  localparam int R0 = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rb_state_e;

endpackage

// File: rtl/reg_bank_init.sv
// Clear engine for the register bank. After reset it walks the register
// indices 1..NREGS-1 one per clock, requesting a zero write for each, and
// holds busy high until the last register has been cleared.
module reg_bank_init
  import rb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] FIRST_IDX = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_STEP  = {{(ADDR_W-1){1'b0}}, 1'b1};

  rb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset restarts the clear walk at index 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and clear-write request; the counter holds once the
  // last index is reached so it can never wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = READY;
          cnt_d   = cnt_q;
        end else begin
          state_d = CLEAR;
          cnt_d   = cnt_q + IDX_STEP;
        end
      end
      READY: begin
        state_d = READY;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = FIRST_IDX;
      end
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Register bank on the receive side of the write-back path.
// Two combinational read ports, one synchronous write port, register 0
// hardwired to zero, and a post-reset clear engine that zeroes every
// register while busy is high. Writes arriving while busy are dropped and
// flagged on the sticky wr_dropped output.
// Optional build macro REG_BANK_BYPASS_EN: when defined, a read that hits
// the register being written in the same cycle returns in_WB directly.
module reg_bank
  import rb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              WE_RB,
  input  logic [ADDR_W-1:0] addr_W,
  input  logic [DATA_W-1:0] in_WB,
  input  logic [ADDR_W-1:0] addr_A,
  input  logic [ADDR_W-1:0] addr_B,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic              busy,
  output logic              wr_dropped
);

  localparam int                NREGS   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(R0);
  localparam logic [DATA_W-1:0] ZERO_W  = {DATA_W{1'b0}};

  logic                busy_s;
  logic                clr_we_s;
  logic [ADDR_W-1:0]   clr_addr_s;
  logic                wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic                drop_s;
  logic                wr_dropped_q;
  logic [DATA_W-1:0]   regs_q [NREGS];

  reg_bank_init #(
    .ADDR_W (ADDR_W)
  ) u_init (
    .clock    (clock),
    .reset    (reset),
    .busy     (busy_s),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // Write-port mux: the clear engine owns the port while busy; otherwise
  // the control unit writes, with register 0 writes discarded.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = clr_addr_s;
    wr_data_s = ZERO_W;
    if (reset) begin
      wr_en_s = 1'b0;
    end else if (busy_s) begin
      wr_en_s   = clr_we_s;
      wr_addr_s = clr_addr_s;
      wr_data_s = ZERO_W;
    end else begin
      wr_en_s   = WE_RB && (addr_W != R0_ADDR);
      wr_addr_s = addr_W;
      wr_data_s = in_WB;
    end
  end

  // Storage for registers 1..NREGS-1; entry 0 is never written and never
  // observed because reads of index 0 are forced to zero.
  always_ff @(posedge clock) begin
    for (int i = 1; i < NREGS; i++) begin
      if (wr_en_s && (wr_addr_s == ADDR_W'(i))) begin
        regs_q[i] <= wr_data_s;
      end else begin
        regs_q[i] <= regs_q[i];
      end
    end
  end

  // A real write (non-zero index) lost to the clear sequence.
  always_comb begin
    drop_s = busy_s && WE_RB && (addr_W != R0_ADDR);
  end

  // Sticky dropped-write flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_dropped_q <= 1'b0;
    end else if (drop_s) begin
      wr_dropped_q <= 1'b1;
    end else begin
      wr_dropped_q <= wr_dropped_q;
    end
  end

  // Read ports: zero while clearing or for index 0, optional write-through,
  // otherwise the stored word.
  always_comb begin
    out_A = ZERO_W;
    out_B = ZERO_W;
    if (busy_s || (addr_A == R0_ADDR)) begin
      out_A = ZERO_W;
`ifdef REG_BANK_BYPASS_EN
    end else if (WE_RB && (addr_W != R0_ADDR) && (addr_A == addr_W)) begin
      out_A = in_WB;
`endif
    end else begin
      out_A = regs_q[addr_A];
    end
    if (busy_s || (addr_B == R0_ADDR)) begin
      out_B = ZERO_W;
`ifdef REG_BANK_BYPASS_EN
    end else if (WE_RB && (addr_W != R0_ADDR) && (addr_B == addr_W)) begin
      out_B = in_WB;
`endif
    end else begin
      out_B = regs_q[addr_B];
    end
  end

  assign busy       = busy_s;
  assign wr_dropped = wr_dropped_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: a behavioural model of the bank
// (array of words plus a countdown of clear edges) is compared against the
// DUT on every falling edge, and directed scenarios pin literal values.
module tb_reg_bank;

  logic        clock;
  logic        reset;
  logic        WE_RB;
  logic [4:0]  addr_W;
  logic [31:0] in_WB;
  logic [4:0]  addr_A;
  logic [4:0]  addr_B;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic        busy;
  logic        wr_dropped;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] mem [32];
  int          clear_left = 0;
  logic        m_drop = 1'b0;
  logic        model_valid = 1'b0;

  reg_bank dut (
    .clock      (clock),
    .reset      (reset),
    .WE_RB      (WE_RB),
    .addr_W     (addr_W),
    .in_WB      (in_WB),
    .addr_A     (addr_A),
    .addr_B     (addr_B),
    .out_A      (out_A),
    .out_B      (out_B),
    .busy       (busy),
    .wr_dropped (wr_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (clear_left > 0) return 32'h0;
    if (a == 5'd0) return 32'h0;
`ifdef REG_BANK_BYPASS_EN
    if (WE_RB && addr_W != 5'd0 && a == addr_W) return in_WB;
`endif
    return mem[a];
  endfunction

  // Model update: reset schedules 31 clear edges and empties the bank;
  // writes during clearing are lost and flagged; afterwards they land.
  always @(posedge clock) begin
    if (reset) begin
      clear_left  = 31;
      m_drop      = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (clear_left > 0) begin
        if (WE_RB && addr_W != 5'd0) m_drop = 1'b1;
        clear_left = clear_left - 1;
      end else if (WE_RB && addr_W != 5'd0) begin
        mem[addr_W] = in_WB;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (model_valid) begin
      check("busy", {31'd0, busy}, {31'd0, (clear_left > 0)});
      check("wr_dropped", {31'd0, wr_dropped}, {31'd0, m_drop});
      check("out_A", out_A, exp_read(addr_A));
      check("out_B", out_B, exp_read(addr_B));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts edges until busy falls, bounded.
  task automatic count_busy(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 100);
  endtask

  int n_edges;

  initial begin
    reset  = 1'b1;
    WE_RB  = 1'b0;
    addr_W = 5'd0;
    in_WB  = 32'h0;
    addr_A = 5'd0;
    addr_B = 5'd0;

    // Phase 1: reset two cycles, release, busy lasts 31 edges.
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_dropped", {31'd0, wr_dropped}, 32'd0);
    reset = 1'b0;
    count_busy(n_edges);
    check("busy_edges", n_edges, 32'd31);
    for (int i = 1; i < 32; i++) begin
      addr_A = 5'(i);
      addr_B = 5'(32 - i);
      #1;
      check("sweep_A", out_A, 32'h0);
      check("sweep_B", out_B, 32'h0);
      tick();
    end

    // Phase 2: READY writes and reads.
    WE_RB = 1'b1; addr_W = 5'd5; in_WB = 32'hFFFF0000;
    tick();
    addr_W = 5'd6; in_WB = 32'h0000FFFF;
    tick();
    WE_RB = 1'b0; addr_A = 5'd5; addr_B = 5'd6;
    #1;
    check("r5", out_A, 32'hFFFF0000);
    check("r6", out_B, 32'h0000FFFF);
    addr_A = 5'd6; addr_B = 5'd6;
    #1;
    check("same_A", out_A, 32'h0000FFFF);
    check("same_B", out_B, 32'h0000FFFF);
    WE_RB = 1'b1; addr_W = 5'd0; in_WB = 32'hFFFFFFFF;
    tick();
    WE_RB = 1'b0; addr_A = 5'd0;
    #1;
    check("r0_zero", out_A, 32'h0);
    check("r0_nodrop", {31'd0, wr_dropped}, 32'd0);

    // Same-cycle write and read of r7.
    addr_A = 5'd7; WE_RB = 1'b1; addr_W = 5'd7; in_WB = 32'hA5A5A5A5;
    #1;
`ifdef REG_BANK_BYPASS_EN
    check("r7_before", out_A, 32'hA5A5A5A5);
`else
    check("r7_before", out_A, 32'h0);
`endif
    tick();
    WE_RB = 1'b0;
    #1;
    check("r7_after", out_A, 32'hA5A5A5A5);

    // Phase 3: writes during CLEAR, then reset mid-clear.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    WE_RB = 1'b1; addr_W = 5'd0; in_WB = 32'hDEADBEEF;
    tick();
    WE_RB = 1'b0;
    check("clr_r0_nodrop", {31'd0, wr_dropped}, 32'd0);
    WE_RB = 1'b1; addr_W = 5'd3; in_WB = 32'h12345678;
    tick();
    WE_RB = 1'b0;
    check("clr_drop", {31'd0, wr_dropped}, 32'd1);
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    check("rerst_busy", {31'd0, busy}, 32'd1);
    check("rerst_dropped", {31'd0, wr_dropped}, 32'd0);
    reset = 1'b0;
    count_busy(n_edges);
    check("busy_edges2", n_edges, 32'd31);
    addr_A = 5'd3; addr_B = 5'd5;
    #1;
    check("r3_zero", out_A, 32'h0);
    check("r5_cleared", out_B, 32'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
